// File: rtl/cf_gpio_pkg.sv
// cf_gpio_pkg: pad mode codes, Sky130 drive-mode codes and sequencer FSM states
package cf_gpio_pkg;
  localparam logic [2:0] MODE_ANALOG   = 3'd0;
  localparam logic [2:0] MODE_INPUT    = 3'd1;
  localparam logic [2:0] MODE_INPUT_PD = 3'd2;
  localparam logic [2:0] MODE_INPUT_PU = 3'd3;
  localparam logic [2:0] MODE_OUTPUT   = 3'd4;
  localparam logic [2:0] MODE_BIDIR    = 3'd5;
  localparam logic [2:0] DM_ANALOG   = 3'b000;
  localparam logic [2:0] DM_INPUT    = 3'b001;
  localparam logic [2:0] DM_PULLUP   = 3'b010;
  localparam logic [2:0] DM_PULLDOWN = 3'b011;
  localparam logic [2:0] DM_STRONG   = 3'b110;
  typedef enum logic [1:0] {ST_IDLE, ST_ISOLATE, ST_COMMIT} state_t;
endpackage

// File: rtl/cf_gpio_pad_decode.sv
// cf_gpio_pad_decode: maps one pad's mode (or isolation) onto its pad-config fields
// ports: mode/isolate/io_out/io_oeb in; dm, inp_dis, oeb, out_val out (all combinational)
module cf_gpio_pad_decode
  import cf_gpio_pkg::*;
(
  input  logic [2:0] mode,
  input  logic       isolate,
  input  logic       io_out,
  input  logic       io_oeb,
  output logic [2:0] dm,
  output logic       inp_dis,
  output logic       oeb,
  output logic       out_val
);
  logic [2:0] m;
  logic       drive;
  always_comb begin
    m       = isolate ? MODE_INPUT : mode;
    drive   = m == MODE_OUTPUT || m == MODE_BIDIR;
    dm      = m == MODE_ANALOG   ? DM_ANALOG   :
              m == MODE_INPUT_PD ? DM_PULLDOWN :
              m == MODE_INPUT_PU ? DM_PULLUP   :
              drive              ? DM_STRONG   : DM_INPUT;
    inp_dis = m == MODE_ANALOG || m == MODE_OUTPUT;
    oeb     = m == MODE_BIDIR ? io_oeb :
              !(m == MODE_INPUT_PD || m == MODE_INPUT_PU || m == MODE_OUTPUT);
    out_val = m == MODE_INPUT_PU || (drive && io_out);
  end
endmodule

// File: rtl/cf_gpio_mode_sequencer.sv
// cf_gpio_mode_sequencer: per-pad mode registers with break-before-make mode changes
// ports: req_* valid/ready change port; done/err/busy status; mode_cur committed modes;
//        io_* user side, gpio_* openframe pad-config side
module cf_gpio_mode_sequencer
  import cf_gpio_pkg::*;
#(
  parameter int NUM_PADS      = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [$clog2(NUM_PADS)-1:0] req_pad,
  input  logic [2:0]                  req_mode,
  output logic                        done,
  output logic                        err,
  output logic                        busy,
  output logic [3*NUM_PADS-1:0]       mode_cur,
  input  logic [NUM_PADS-1:0]         io_out,
  input  logic [NUM_PADS-1:0]         io_oeb,
  output logic [NUM_PADS-1:0]         io_in,
  input  logic [NUM_PADS-1:0]         gpio_in,
  output logic [3*NUM_PADS-1:0]       gpio_dm,
  output logic [NUM_PADS-1:0]         gpio_inp_dis,
  output logic [NUM_PADS-1:0]         gpio_oeb_out,
  output logic [NUM_PADS-1:0]         gpio_out_val
);
  localparam int PW = $clog2(NUM_PADS);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         pad_q, pad_d;
  logic [2:0]            mode_q, mode_d;
  logic [3*NUM_PADS-1:0] modes_q, modes_d;
  logic                  done_q, done_d, err_q, err_d;
  logic                  accept, bad;
  assign req_ready = state_q == ST_IDLE && !rst;
  assign busy      = state_q != ST_IDLE;
  assign done      = done_q;
  assign err       = err_q;
  assign mode_cur  = modes_q;
  assign io_in     = gpio_in;
  assign accept    = req_valid && req_ready;
  assign bad       = req_mode > MODE_BIDIR || 32'(req_pad) >= NUM_PADS;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pad_d   = pad_q;
    mode_d  = mode_q;
    modes_d = modes_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && bad) err_d = 1'b1;
        else if (accept && req_mode == modes_q[int'(req_pad)*3 +: 3]) done_d = 1'b1;
        else if (accept) begin
          state_d = ST_ISOLATE;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
          pad_d   = req_pad;
          mode_d  = req_mode;
        end
      end
      ST_ISOLATE: begin
        if (cnt_q == '0) begin
          state_d                      = ST_COMMIT;
          modes_d[int'(pad_q)*3 +: 3] = mode_q;
          done_d                       = 1'b1;
        end else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pad_q   <= '0;
      mode_q  <= MODE_INPUT;
      modes_q <= {NUM_PADS{MODE_INPUT}};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pad_q   <= pad_d;
      mode_q  <= mode_d;
      modes_q <= modes_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    cf_gpio_pad_decode u_dec (
      .mode    (modes_q[3*i +: 3]),
      .isolate (state_q == ST_ISOLATE && pad_q == PW'(i)),
      .io_out  (io_out[i]),
      .io_oeb  (io_oeb[i]),
      .dm      (gpio_dm[3*i +: 3]),
      .inp_dis (gpio_inp_dis[i]),
      .oeb     (gpio_oeb_out[i]),
      .out_val (gpio_out_val[i])
    );
  end
endmodule

// File: doc/cf_gpio_mode_sequencer.md
# cf_gpio_mode_sequencer

Runtime mode controller for a bank of Sky130 Openframe GPIO pads. It holds one 3-bit mode register per pad and decodes each register into the pad configuration fields. Mode changes arrive through a valid/ready request port. Each change is applied break-before-make: the target pad is isolated for a settle interval, then the new mode is committed. The block sits between the user design (or a CSR block) and the openframe_project_wrapper pad-config buses.

## Interface
Parameters:
- NUM_PADS, 8: number of pads managed; must be ≥2.
- SETTLE_CYCLES, 4: cycles the target pad stays isolated before commit; must be ≥1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset: one clock, synchronous, active-high.
- req_valid  in  1  mode-change request valid.
- req_ready  out  1  request accepted on the cycle where valid&&ready.
- req_pad  in  $clog2(NUM_PADS)  target pad index.
- req_mode  in  3  new mode: 0=ANALOG, 1=INPUT, 2=INPUT_PD, 3=INPUT_PU, 4=OUTPUT, 5=BIDIR.
- done  out  1  one-cycle pulse when a request completes (commit or no-op).
- err  out  1  one-cycle pulse when a request is rejected.
- busy  out  1  high while not IDLE.
- mode_cur  out  3*NUM_PADS  committed mode per pad; pad i is at [3i+2:3i].
- io_out, io_oeb  in  NUM_PADS  user data and output-enable-bar per pad.
- io_in  out  NUM_PADS  equals gpio_in; pure passthrough.
- gpio_in  in  NUM_PADS  pad inputs.
- gpio_dm  out  3*NUM_PADS  drive mode per pad.
- gpio_inp_dis, gpio_oeb_out, gpio_out_val  out  NUM_PADS  pad controls.

## Operation
- Per-pad decode from the committed mode:
  - ANALOG: dm=000, inp_dis=1, oeb=1, out=0.
  - INPUT: dm=001, inp_dis=0, oeb=1, out=0.
  - INPUT_PD: dm=011, inp_dis=0, oeb=0, out=0.
  - INPUT_PU: dm=010, inp_dis=0, oeb=0, out=1.
  - OUTPUT: dm=110, inp_dis=1, oeb=0, out=io_out[i].
  - BIDIR: dm=110, inp_dis=0, oeb=io_oeb[i], out=io_out[i].
- Isolated pad: forced to the INPUT fields (dm=001, inp_dis=0, oeb=1, out=0), regardless of its mode register.
- FSM states:
  - IDLE → ISOLATE on accept when req_mode ≤5, req_pad < NUM_PADS and req_mode ≠ mode_cur[pad].
  - ISOLATE → COMMIT when the settle counter reaches 0.
  - COMMIT → IDLE unconditionally.
- Accept with req_mode ≥6 or req_pad ≥ NUM_PADS: no state change, err pulse. Invalid mode takes precedence.
- Accept with req_mode equal to the current mode: no isolation, done pulse only.
- Only the target pad is isolated; all other pads keep their decoded outputs throughout.
- Reset state: all mode registers = INPUT (001), FSM=IDLE, counter=0, isolation cleared.
- Reset output values:
  - every pad: dm=001, inp_dis=0, oeb=1, out_val=0;
  - req_ready=0 while rst is high;
  - done=0, err=0, busy=0.

## Timing
- req_ready = (state==IDLE) && !rst. Combinational from state; no dependency on req_valid.
- Accept at cycle T (normal change):
  - T+1..T+SETTLE_CYCLES: state=ISOLATE; target pad isolated; busy=1.
  - T+SETTLE_CYCLES+1: state=COMMIT; mode register updated; isolation released; pad shows new-mode fields; done=1; busy=1; req_ready=0.
  - T+SETTLE_CYCLES+2: IDLE; req_ready=1.
  - Total: SETTLE_CYCLES+2 cycles from accept to the next possible accept.
- No-op or error accept at T: done or err pulses at T+1; the FSM stays IDLE, so req_ready stays 1 and back-to-back requests are accepted.
- Settle counter: width $clog2(SETTLE_CYCLES+1). Loaded with SETTLE_CYCLES-1 on accept; decrements in ISOLATE; no wrap.
- req_pad and req_mode are captured on accept; later changes on those inputs are ignored.
- Pad outputs are combinational from the registers plus io_out/io_oeb. Zero latency from io_out/io_oeb to the pad.
- rst mid-ISOLATE: next cycle all pads return to the INPUT reset values, the pending change is dropped, and neither done nor err fires.

## Structure
- Package cf_gpio_pkg:
  - mode localparams MODE_ANALOG..MODE_BIDIR (3 bits);
  - FSM state encoding {IDLE, ISOLATE, COMMIT};
  - DM constants.
- Sub-module cf_gpio_pad_decode: combinational; takes mode[2:0], isolate, io_out, io_oeb and produces dm, inp_dis, oeb, out_val. Instantiated NUM_PADS times via generate.
- The top level holds the FSM, settle counter, captured pad/mode, and the mode-register array.

## Test plan
- Reset release: every pad shows dm=001, oeb=1, out_val=0, inp_dis=0; mode_cur is all 001; req_ready rises in the first cycle after rst falls.
- Pad 3 to OUTPUT (4) with SETTLE_CYCLES=4, accepted at T:
  - T+1..T+4: pad 3 isolated (oeb=1, dm=001);
  - T+5: dm=110, oeb=0, out_val tracks io_out[3], done=1;
  - other pads unchanged throughout.
- Pad 1 to INPUT_PU, then pad 2 to BIDIR: pad 1 shows dm=010, oeb=0, out_val=1; pad 2's oeb follows io_oeb[2] toggling with zero delay.
- req_mode=7 → err at T+1, no mode change, req_ready stays 1. A same-mode request → done at T+1 with no isolation cycle.
- Assert rst at T+2 of a pending OUTPUT change → all pads return to INPUT, done never fires, and the next request completes normally.
